// File: rtl/approx_err_monitor.sv
// -----------------------------------------------------------------------------
// approx_err_monitor
//   Error-statistics stage that sits behind the 8x8 truncated Dadda multiplier.
//   Each accepted sample {a, b, p_approx} is compared against the exact product.
//   Over a run of N_SAMPLES samples the block accumulates the sample count,
//   the error count, the overshoot count, a saturating ED sum and the max ED.
//
//   Ports
//     clk       rising-edge clock
//     rst       synchronous active-high reset, priority over everything
//     start     run start pulse, honoured in IDLE and DONE only
//     in_valid  sample valid
//     in_ready  sample ready (registered, independent of in_valid)
//     a, b      operands of the sample
//     p_approx  product from the approximate multiplier
//     busy      high in RUN and DRAIN
//     done      high in DONE; results stable
//     smp_cnt   samples accumulated
//     err_cnt   samples with ED != 0
//     over_cnt  samples with p_approx > exact
//     ed_sum    saturating sum of ED
//     ed_max    largest ED seen
//     sum_sat   sticky flag, ed_sum saturated
//
//   Pipeline: capture on acceptance (edge t), ED/overshoot at t+1, stats at t+2.
//   DRAIN lasts exactly two cycles so the last sample lands in the stats on the
//   same edge that moves the FSM into DONE.
// -----------------------------------------------------------------------------
module approx_err_monitor #(
  parameter int WIDTH     = 8,
  parameter int N_SAMPLES = 256,
  parameter int CNT_W     = 17,
  parameter int SUM_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   p_approx,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     smp_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     over_cnt,
  output logic [SUM_W-1:0]     ed_sum,
  output logic [2*WIDTH-1:0]   ed_max,
  output logic                 sum_sat
);

  localparam int PW     = 2 * WIDTH;
  localparam int STAGES = 2;
  // Accumulator add is done one bit wider than the larger operand so the
  // carry shows whether the true sum exceeds the representable maximum.
  localparam int ACC_W  = ((SUM_W > PW) ? SUM_W : PW) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_clear;
  logic               w_accept;
  logic               w_last;

  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_acc_cnt;
  logic               r_drain_cnt;

  logic [STAGES-1:0]  r_vld_pipe;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [PW-1:0]      r_p0;
  logic [PW-1:0]      r_ed1;
  logic               r_ov1;

  logic [PW-1:0]      w_exact;
  logic               w_ov;
  logic [PW-1:0]      w_ed;
  logic [ACC_W-1:0]   w_sum_ext;
  logic               w_sum_ovf;

  logic [CNT_W-1:0]   r_smp_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CNT_W-1:0]   r_over_cnt;
  logic [SUM_W-1:0]   r_ed_sum;
  logic [PW-1:0]      r_ed_max;
  logic               r_sum_sat;

  // in_ready is a register, so acceptance never loops through in_valid.
  assign w_accept = in_valid & r_in_ready;
  assign w_last   = w_accept && (r_acc_cnt == CNT_W'(N_SAMPLES - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // start is deliberately not looked at here, including on the last
        // acceptance.
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain_cnt) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_acc_cnt   <= '0;
      r_drain_cnt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // Status outputs decoded from the next state so they are registered
      // and line up with the state register.
      r_in_ready  <= (w_state_nxt == S_RUN);
      r_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_done      <= (w_state_nxt == S_DONE);
      if (w_clear)       r_acc_cnt <= '0;
      else if (w_accept) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      r_drain_cnt <= (r_state == S_DRAIN) && !r_drain_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample pipeline
  // ---------------------------------------------------------------------------
  assign w_exact = PW'(r_a) * PW'(r_b);
  assign w_ov    = (r_p0 > w_exact);
  assign w_ed    = w_ov ? (r_p0 - w_exact) : (w_exact - r_p0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_p0       <= '0;
      r_ed1      <= '0;
      r_ov1      <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-2:0], w_accept};
      if (w_accept) begin
        r_a  <= a;
        r_b  <= b;
        r_p0 <= p_approx;
      end
      if (r_vld_pipe[0]) begin
        r_ed1 <= w_ed;
        r_ov1 <= w_ov;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  assign w_sum_ext = ACC_W'(r_ed_sum) + ACC_W'(r_ed1);
  assign w_sum_ovf = (w_sum_ext > ACC_W'({SUM_W{1'b1}}));

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_smp_cnt  <= '0;
      r_err_cnt  <= '0;
      r_over_cnt <= '0;
      r_ed_sum   <= '0;
      r_ed_max   <= '0;
      r_sum_sat  <= 1'b0;
    end else if (r_vld_pipe[STAGES-1]) begin
      r_smp_cnt <= r_smp_cnt + CNT_W'(1);
      if (r_ed1 != '0) r_err_cnt  <= r_err_cnt + CNT_W'(1);
      if (r_ov1)       r_over_cnt <= r_over_cnt + CNT_W'(1);
      if (r_ed1 > r_ed_max) r_ed_max <= r_ed1;
      if (w_sum_ovf) begin
        r_ed_sum  <= {SUM_W{1'b1}};
        r_sum_sat <= 1'b1;
      end else begin
        r_ed_sum  <= w_sum_ext[SUM_W-1:0];
      end
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign smp_cnt  = r_smp_cnt;
  assign err_cnt  = r_err_cnt;
  assign over_cnt = r_over_cnt;
  assign ed_sum   = r_ed_sum;
  assign ed_max   = r_ed_max;
  assign sum_sat  = r_sum_sat;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench: each run's expected statistics are computed from the raw
// samples with plain arithmetic and queued; a monitor pops and compares when
// done rises. Directed checks cover reset, latency and saturation.
module tb_approx_err_monitor;
  localparam int W  = 8;
  localparam int PW = 2 * W;
  localparam int N  = 8;
  localparam int CW = 17;
  localparam int SW = 16;
  localparam longint SMAX = (longint'(1) << SW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready;
  logic [W-1:0]  a, b;
  logic [PW-1:0] p_approx;
  logic          busy, done, sum_sat;
  logic [CW-1:0] smp_cnt, err_cnt, over_cnt;
  logic [SW-1:0] ed_sum;
  logic [PW-1:0] ed_max;

  always #5 clk = ~clk;

  approx_err_monitor #(.WIDTH(W), .N_SAMPLES(N), .CNT_W(CW), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .p_approx(p_approx), .busy(busy), .done(done),
    .smp_cnt(smp_cnt), .err_cnt(err_cnt), .over_cnt(over_cnt),
    .ed_sum(ed_sum), .ed_max(ed_max), .sum_sat(sum_sat)
  );

  typedef struct {
    longint smp, err, over, sum, mx;
    bit     sat;
  } res_t;
  res_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;

  // reference model: raw totals of the current run
  longint m_smp, m_err, m_over, m_tot, m_max;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    m_smp = 0; m_err = 0; m_over = 0; m_tot = 0; m_max = 0;
  endtask

  task automatic model_add(input int av, input int bv, input int pv);
    longint ex, ed;
    ex = longint'(av) * longint'(bv);
    ed = (ex > pv) ? ex - pv : pv - ex;
    m_smp++;
    if (ed != 0) m_err++;
    if (pv > ex) m_over++;
    m_tot += ed;
    if (ed > m_max) m_max = ed;
  endtask

  function automatic longint exp_sum();
    return (m_tot > SMAX) ? SMAX : m_tot;
  endfunction

  task automatic check_stats(input string tag);
    chk({tag, "_smp"},  smp_cnt,  m_smp);
    chk({tag, "_err"},  err_cnt,  m_err);
    chk({tag, "_over"}, over_cnt, m_over);
    chk({tag, "_sum"},  ed_sum,   exp_sum());
    chk({tag, "_max"},  ed_max,   m_max);
    chk({tag, "_sat"},  sum_sat,  longint'(m_tot > SMAX));
  endtask

  // Offers one sample until accepted; random start pulses ride along and must
  // be ignored because the FSM is in RUN.
  task automatic accept_one(input int av, input int bv, input int pv, input bit gap);
    int cyc;
    if (gap) begin
      repeat ($urandom_range(1, 2)) begin
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); p_approx = PW'($urandom);
        step();
      end
    end
    a = W'(av); b = W'(bv); p_approx = PW'(pv);
    in_valid = 1'b1;
    start = ($urandom_range(0, 5) == 0);
    cyc = 0;
    while (!in_ready && cyc < 50) begin step(); cyc++; end
    if (!in_ready) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", cyc);
      in_valid = 1'b0; start = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    start = 1'b0;
    model_add(av, bv, pv);
  endtask

  task automatic begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
    chk("run_busy",  busy,     1);
    chk("run_ready", in_ready, 1);
    chk("run_done",  done,     0);
    chk("run_clr_smp", smp_cnt, 0);
    chk("run_clr_sum", ed_sum,  0);
  endtask

  // Called right after the edge of the last acceptance.
  task automatic finish_run();
    res_t r;
    r.smp = m_smp; r.err = m_err; r.over = m_over; r.sum = exp_sum();
    r.mx = m_max; r.sat = (m_tot > SMAX);
    exp_q.push_back(r);
    chk("ready_drop", in_ready, 0);
    chk("drain_done0", done, 0);
    // offered samples in DRAIN must not be taken
    in_valid = 1'b1; a = W'($urandom); b = W'($urandom); p_approx = PW'($urandom);
    step();
    chk("drain_done1", done, 0);
    chk("drain_busy",  busy, 1);
    step();
    chk("done_rise", done, 1);
    chk("done_busy", busy, 0);
    in_valid = 1'b0;
    step();
  endtask

  task automatic rand_run(input int mode);
    int av, bv, pv;
    longint ex, pp;
    begin_run();
    for (int i = 0; i < N; i++) begin
      av = int'($urandom_range(0, 255));
      bv = int'($urandom_range(0, 255));
      ex = longint'(av) * longint'(bv);
      if (mode == 0) pp = ex + longint'($urandom_range(0, 600)) - 300;
      else           pp = longint'($urandom_range(0, 65535));
      if (pp < 0) pp = 0;
      if (pp > 65535) pp = 65535;
      pv = int'(pp);
      accept_one(av, bv, pv, bit'($urandom_range(0, 1)));
    end
    finish_run();
  endtask

  // Scoreboard monitor
  initial begin
    bit   dq;
    res_t r;
    dq = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !dq) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL sb_unexpected_done: done rose with no run pending");
        end else begin
          r = exp_q.pop_front();
          chk("sb_smp",  smp_cnt,  r.smp);
          chk("sb_err",  err_cnt,  r.err);
          chk("sb_over", over_cnt, r.over);
          chk("sb_sum",  ed_sum,   r.sum);
          chk("sb_max",  ed_max,   r.mx);
          chk("sb_sat",  sum_sat,  longint'(r.sat));
        end
      end
      dq = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; p_approx = '0;
    repeat (3) step();
    chk("rst_ready", in_ready, 0);
    chk("rst_busy",  busy,     0);
    chk("rst_done",  done,     0);
    model_clear();
    check_stats("rst");
    rst = 1'b0;
    step();
    chk("idle_ready", in_ready, 0);

    // Exact products only: no error anywhere.
    begin_run();
    for (int i = 0; i < N; i++) accept_one(255, 255, 65025, 1'b0);
    finish_run();

    // Directed ED values, with explicit two-edge latency.
    begin_run();
    accept_one(200, 100, 19960, 1'b0);
    step();
    chk("lat_t1_smp", smp_cnt, 0);
    step();
    chk("s1_sum", ed_sum, 40);
    chk("s1_max", ed_max, 40);
    chk("s1_err", err_cnt, 1);
    chk("s1_over", over_cnt, 0);
    accept_one(200, 100, 20010, 1'b0);
    step(); step();
    chk("s2_sum", ed_sum, 50);
    chk("s2_max", ed_max, 40);
    chk("s2_over", over_cnt, 1);
    check_stats("s2");
    for (int i = 2; i < N; i++)
      accept_one(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 65535)), 1'b0);
    finish_run();

    // in_valid toggling: every sample preceded by idle cycles.
    begin_run();
    for (int i = 0; i < N; i++)
      accept_one(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 65535)), 1'b1);
    finish_run();

    // Saturation: ED = 65535 with a 16-bit accumulator.
    begin_run();
    accept_one(0, int'($urandom_range(0, 255)), 65535, 1'b0);
    step(); step();
    chk("sat1_sum", ed_sum, 65535);
    chk("sat1_flag", sum_sat, 0);
    accept_one(0, int'($urandom_range(0, 255)), 65535, 1'b1);
    step(); step();
    chk("sat2_sum", ed_sum, 65535);
    chk("sat2_flag", sum_sat, 1);
    check_stats("sat2");
    for (int i = 2; i < N; i++)
      accept_one(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 65535)), 1'b0);
    finish_run();

    // Reset mid-run with samples in flight.
    begin_run();
    for (int i = 0; i < 3; i++)
      accept_one(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), 7, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    chk("mrst_ready", in_ready, 0);
    chk("mrst_busy",  busy, 0);
    chk("mrst_done",  done, 0);
    check_stats("mrst");
    step(); step();
    check_stats("mrst_flush");
    chk("mrst_idle", in_ready, 0);

    for (int r = 0; r < 8; r++) rand_run(r % 2);

    repeat (4) step();
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
